led_pwm_ctrl_axil: RTL and testbench

AXI4-Lite register slave driving NUM_LEDS LED outputs, each with an independent mode: off, on, PWM dimming or blinking PWM. It generalises the four-register LED controller to a parametrised channel count, adds a shared prescaler, PWM and blink timebase, and returns SLVERR on unmapped addresses. It sits behind the PS AXI GP interconnect, and its LED outputs go straight to board pins.

---
 rtl/led_pwm_ctrl_pkg.sv | 29 ++
 rtl/led_pwm_ctrl_axil_timebase.sv | 74 +++++++
 rtl/led_pwm_ctrl_axil.sv | 244 ++++++++++++++++++++++++
 tb/tb_led_pwm_ctrl_axil.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_ctrl_pkg.sv
// Shared definitions for the AXI4-Lite LED PWM controller: register map,
// LED mode encoding and response codes.
package led_pwm_ctrl_pkg;

  localparam int unsigned ADDR_CTRL     = 32'h00;
  localparam int unsigned ADDR_PRESCALE = 32'h04;
  localparam int unsigned ADDR_BLINK    = 32'h08;
  localparam int unsigned ADDR_STATUS   = 32'h0C;
  localparam int unsigned ADDR_LED_BASE = 32'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_PWM   = 2'd2,
    LED_BLINK = 2'd3
  } led_mode_t;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/led_pwm_ctrl_axil_timebase.sv
// Shared timebase: prescaler, PWM frame counter and blink phase generator.
// All counters are held at zero whenever run_i is low.
import led_pwm_ctrl_pkg::*;

module led_pwm_timebase #(
  parameter int PWM_W   = 8,
  parameter int PRESC_W = 16
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               run_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic [15:0]        blink_i,
  output logic [PWM_W-1:0]   pwm_cnt_o,
  output logic               blink_phase_o
);

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [15:0]        blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic               tick;
  logic               frame_end;
  logic [15:0]        blink_lim;

  assign tick      = (presc_cnt_q == presc_i);
  assign frame_end = tick && (pwm_cnt_q == {PWM_W{1'b1}});
  // A half-period of 0 behaves like 1 frame.
  assign blink_lim = (blink_i == 16'd0) ? 16'd0 : blink_i - 16'd1;

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    pwm_cnt_d   = pwm_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!run_i) begin
      presc_cnt_d = '0;
      pwm_cnt_d   = '0;
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else begin
      presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
      if (tick) begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
      end
      if (frame_end) begin
        if (blink_cnt_q == blink_lim) begin
          blink_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign pwm_cnt_o     = pwm_cnt_q;
  assign blink_phase_o = phase_q;

endmodule

// File: rtl/led_pwm_ctrl_axil.sv
// AXI4-Lite register slave driving NUM_LEDS LEDs in off/on/pwm/blink modes.
//   state     | meaning
//   WR_IDLE   | waiting for AW and W together with no response pending
//   WR_ACCEPT | awready/wready high; register write commits on this edge
//   WR_RESP   | bvalid held until bready
//   RD_IDLE   | waiting for AR with no read data pending
//   RD_ACCEPT | arready high; read data captured on this edge
//   RD_DATA   | rvalid/rdata/rresp held until rready
import led_pwm_ctrl_pkg::*;

module led_pwm_ctrl_axil #(
  parameter int NUM_LEDS           = 8,
  parameter int PWM_W              = 8,
  parameter int PRESC_W            = 16,
  parameter int C_S_AXI_ADDR_WIDTH = 8
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr_i,
  input  logic                          s_axi_awvalid_i,
  output logic                          s_axi_awready_o,
  input  logic [31:0]                   s_axi_wdata_i,
  input  logic [3:0]                    s_axi_wstrb_i,
  input  logic                          s_axi_wvalid_i,
  output logic                          s_axi_wready_o,
  output logic [1:0]                    s_axi_bresp_o,
  output logic                          s_axi_bvalid_o,
  input  logic                          s_axi_bready_i,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr_i,
  input  logic                          s_axi_arvalid_i,
  output logic                          s_axi_arready_o,
  output logic [31:0]                   s_axi_rdata_o,
  output logic [1:0]                    s_axi_rresp_o,
  output logic                          s_axi_rvalid_o,
  input  logic                          s_axi_rready_i,
  output logic [NUM_LEDS-1:0]           led_o
);

  localparam int unsigned NUM_WORDS  = 4 + NUM_LEDS;
  localparam int unsigned W_CTRL     = ADDR_CTRL / 4;
  localparam int unsigned W_PRESCALE = ADDR_PRESCALE / 4;
  localparam int unsigned W_BLINK    = ADDR_BLINK / 4;
  localparam int unsigned W_LED_BASE = ADDR_LED_BASE / 4;

  typedef enum logic [1:0] {WR_IDLE, WR_ACCEPT, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ACCEPT, RD_DATA} rd_state_t;

  wr_state_t wr_state_q;
  rd_state_t rd_state_q;
  logic        awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;

  logic               ctrl_en_q;
  logic [PRESC_W-1:0] presc_q;
  logic [15:0]        blink_q;
  led_mode_t          mode_q [NUM_LEDS];
  logic [PWM_W-1:0]   duty_q [NUM_LEDS];
  logic [NUM_LEDS-1:0] led_q;

  logic [PWM_W-1:0] pwm_cnt;
  logic             blink_phase;
  logic             tb_run;

  logic [31:0] reg_words [NUM_WORDS];
  logic [31:0] aw_idx, ar_idx;
  logic        aw_hit, ar_hit;
  logic [31:0] aw_word, ar_word, wr_new;
  logic        wr_fire;
  logic        unused_bits;

  assign aw_idx  = 32'(s_axi_awaddr_i[C_S_AXI_ADDR_WIDTH-1:2]);
  assign ar_idx  = 32'(s_axi_araddr_i[C_S_AXI_ADDR_WIDTH-1:2]);
  assign aw_hit  = aw_idx < NUM_WORDS;
  assign ar_hit  = ar_idx < NUM_WORDS;
  assign wr_fire = (wr_state_q == WR_ACCEPT) && s_axi_awvalid_i && s_axi_wvalid_i;

  always_comb begin
    for (int i = 0; i < int'(NUM_WORDS); i++) begin
      reg_words[i] = '0;
    end
    reg_words[W_CTRL][0]                 = ctrl_en_q;
    reg_words[W_PRESCALE][PRESC_W-1:0]   = presc_q;
    reg_words[W_BLINK][15:0]             = blink_q;
    reg_words[ADDR_STATUS/4][PWM_W-1:0]  = pwm_cnt;
    reg_words[ADDR_STATUS/4][16]         = blink_phase;
    for (int i = 0; i < NUM_LEDS; i++) begin
      reg_words[W_LED_BASE + 32'(i)][1:0]       = mode_q[i];
      reg_words[W_LED_BASE + 32'(i)][8 +: PWM_W] = duty_q[i];
    end
  end

  always_comb begin
    aw_word = '0;
    ar_word = '0;
    for (int i = 0; i < int'(NUM_WORDS); i++) begin
      if (aw_idx == 32'(i)) aw_word = reg_words[i];
      if (ar_idx == 32'(i)) ar_word = reg_words[i];
    end
  end

  // Byte-lane merge against the current value keeps partial writes exact.
  assign wr_new = (aw_word & ~strb_mask(s_axi_wstrb_i)) |
                  (s_axi_wdata_i & strb_mask(s_axi_wstrb_i));

  // Clearing global_en stops the timebase on the write edge itself.
  assign tb_run = ctrl_en_q && !(wr_fire && (aw_idx == W_CTRL) && !wr_new[0]);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_state_q <= WR_IDLE;
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      case (wr_state_q)
        WR_IDLE: begin
          if (s_axi_awvalid_i && s_axi_wvalid_i && !bvalid_q) begin
            awready_q  <= 1'b1;
            wr_state_q <= WR_ACCEPT;
          end
        end
        WR_ACCEPT: begin
          awready_q <= 1'b0;
          if (s_axi_awvalid_i && s_axi_wvalid_i) begin
            bvalid_q   <= 1'b1;
            bresp_q    <= aw_hit ? RESP_OKAY : RESP_SLVERR;
            wr_state_q <= WR_RESP;
          end else begin
            wr_state_q <= WR_IDLE;
          end
        end
        WR_RESP: begin
          if (s_axi_bready_i) begin
            bvalid_q   <= 1'b0;
            wr_state_q <= WR_IDLE;
          end
        end
        default: wr_state_q <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (s_axi_arvalid_i && !rvalid_q) begin
            arready_q  <= 1'b1;
            rd_state_q <= RD_ACCEPT;
          end
        end
        RD_ACCEPT: begin
          arready_q <= 1'b0;
          if (s_axi_arvalid_i) begin
            rvalid_q   <= 1'b1;
            rdata_q    <= ar_word;
            rresp_q    <= ar_hit ? RESP_OKAY : RESP_SLVERR;
            rd_state_q <= RD_DATA;
          end else begin
            rd_state_q <= RD_IDLE;
          end
        end
        RD_DATA: begin
          if (s_axi_rready_i) begin
            rvalid_q   <= 1'b0;
            rd_state_q <= RD_IDLE;
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ctrl_en_q <= 1'b0;
      presc_q   <= '0;
      blink_q   <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        mode_q[i] <= LED_OFF;
        duty_q[i] <= '0;
      end
    end else if (wr_fire) begin
      if (aw_idx == W_CTRL)     ctrl_en_q <= wr_new[0];
      if (aw_idx == W_PRESCALE) presc_q   <= wr_new[PRESC_W-1:0];
      if (aw_idx == W_BLINK)    blink_q   <= wr_new[15:0];
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (aw_idx == W_LED_BASE + 32'(i)) begin
          mode_q[i] <= led_mode_t'(wr_new[1:0]);
          duty_q[i] <= wr_new[8 +: PWM_W];
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      led_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        case (mode_q[i])
          LED_OFF:   led_q[i] <= 1'b0;
          LED_ON:    led_q[i] <= ctrl_en_q;
          LED_PWM:   led_q[i] <= ctrl_en_q && (duty_q[i] > pwm_cnt);
          LED_BLINK: led_q[i] <= ctrl_en_q && blink_phase && (duty_q[i] > pwm_cnt);
          default:   led_q[i] <= 1'b0;
        endcase
      end
    end
  end

  led_pwm_timebase #(
    .PWM_W   (PWM_W),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .run_i         (tb_run),
    .presc_i       (presc_q),
    .blink_i       (blink_q),
    .pwm_cnt_o     (pwm_cnt),
    .blink_phase_o (blink_phase)
  );

  assign unused_bits = ^{wr_new, s_axi_awaddr_i[1:0], s_axi_araddr_i[1:0]};

  assign s_axi_awready_o = awready_q;
  assign s_axi_wready_o  = awready_q;
  assign s_axi_bvalid_o  = bvalid_q;
  assign s_axi_bresp_o   = bresp_q;
  assign s_axi_arready_o = arready_q;
  assign s_axi_rvalid_o  = rvalid_q;
  assign s_axi_rresp_o   = rresp_q;
  assign s_axi_rdata_o   = rdata_q;
  assign led_o           = led_q;

endmodule

// File: tb/tb_led_pwm_ctrl_axil.sv
// Directed self-checking bench for led_pwm_ctrl_axil with default parameters.
module tb_led_pwm_ctrl_axil;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [7:0]  led;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_pwm_ctrl_axil dut (
    .clock_i         (clk),
    .reset_i         (rst),
    .s_axi_awaddr_i  (awaddr),
    .s_axi_awvalid_i (awvalid),
    .s_axi_awready_o (awready),
    .s_axi_wdata_i   (wdata),
    .s_axi_wstrb_i   (wstrb),
    .s_axi_wvalid_i  (wvalid),
    .s_axi_wready_o  (wready),
    .s_axi_bresp_o   (bresp),
    .s_axi_bvalid_o  (bvalid),
    .s_axi_bready_i  (bready),
    .s_axi_araddr_i  (araddr),
    .s_axi_arvalid_i (arvalid),
    .s_axi_arready_o (arready),
    .s_axi_rdata_o   (rdata),
    .s_axi_rresp_o   (rresp),
    .s_axi_rvalid_o  (rvalid),
    .s_axi_rready_i  (rready),
    .led_o           (led)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic got;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (awready && wready) got = 1'b1;
      tick1();
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("aw_handshake", {31'b0, got}, 32'd1);
    got = 1'b0;
    resp = 2'b11;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bvalid) begin
        got = 1'b1;
        resp = bresp;
        bready = 1'b1;
      end
      tick1();
    end
    bready = 1'b0;
    chk("b_handshake", {31'b0, got}, 32'd1);
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    logic got;
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (arready) got = 1'b1;
      tick1();
    end
    arvalid = 1'b0;
    chk("ar_handshake", {31'b0, got}, 32'd1);
    got = 1'b0;
    data = 32'hDEAD_BEEF;
    resp = 2'b11;
    for (int i = 0; i < 20 && !got; i++) begin
      if (rvalid) begin
        got = 1'b1;
        data = rdata;
        resp = rresp;
        rready = 1'b1;
      end
      tick1();
    end
    rready = 1'b0;
    chk("r_handshake", {31'b0, got}, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic        ok, got;
    int          n;

    rst = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_led", {24'b0, led}, 32'd0);
    chk("reset_hs", {28'b0, awready, bvalid, arready, rvalid}, 32'd0);
    for (int a = 0; a < 12; a++) begin
      axi_read(8'(a * 4), d, r);
      chk($sformatf("reset_rdata_%0h", a * 4), d, 32'd0);
      chk($sformatf("reset_rresp_%0h", a * 4), {30'b0, r}, 32'd0);
    end

    // Mode ON follows global_en
    axi_write(8'h10, 32'h0000_0001, 4'hF, r);
    axi_write(8'h00, 32'h0000_0001, 4'hF, r);
    chk("on_led0_en", {31'b0, led[0]}, 32'd1);
    axi_write(8'h00, 32'h0000_0000, 4'hF, r);
    chk("on_led0_dis", {31'b0, led[0]}, 32'd0);

    // Byte strobe touches only the duty byte
    axi_write(8'h10, 32'h0000_5502, 4'b0010, r);
    axi_read(8'h10, d, r);
    chk("strb_led0", d, 32'h0000_5501);

    // PWM duty 0x40, prescale 0: 64 high clocks per 256
    axi_write(8'h04, 32'h0, 4'hF, r);
    axi_write(8'h14, 32'h0000_4002, 4'hF, r);
    axi_write(8'h00, 32'h0000_0001, 4'hF, r);
    n = 0;
    for (int k = 0; k < 256; k++) begin tick1(); if (led[1]) n++; end
    chk("pwm_duty40", 32'(n), 32'd64);
    axi_write(8'h14, 32'h0000_0002, 4'hF, r);
    n = 0;
    for (int k = 0; k < 256; k++) begin tick1(); if (led[1]) n++; end
    chk("pwm_duty0", 32'(n), 32'd0);
    axi_write(8'h14, 32'h0000_4002, 4'hF, r);
    axi_write(8'h04, 32'h0000_0001, 4'hF, r);
    n = 0;
    for (int k = 0; k < 512; k++) begin tick1(); if (led[1]) n++; end
    chk("pwm_presc1", 32'(n), 32'd128);

    // Blink: duty 0x80, half-period 2 frames
    axi_write(8'h00, 32'h0, 4'hF, r);
    axi_write(8'h14, 32'h0, 4'hF, r);
    axi_write(8'h04, 32'h0, 4'hF, r);
    axi_write(8'h08, 32'h0000_0002, 4'hF, r);
    axi_write(8'h18, 32'h0000_8003, 4'hF, r);
    axi_write(8'h00, 32'h0000_0001, 4'hF, r);
    n = 0;
    for (int k = 0; k < 200; k++) begin tick1(); if (led[2]) n++; end
    chk("blink_phase0_led", 32'(n), 32'd0);
    axi_read(8'h0C, d, r);
    chk("blink_status_ph0", d & 32'h0001_0000, 32'h0);
    repeat (500) @(posedge clk);
    #1;
    axi_read(8'h0C, d, r);
    chk("blink_status_ph1", d & 32'h0001_0000, 32'h0001_0000);
    n = 0;
    for (int k = 0; k < 2048; k++) begin tick1(); if (led[2]) n++; end
    chk("blink_2048", 32'(n), 32'd512);

    // Unmapped accesses
    axi_write(8'h80, 32'hFFFF_FFFF, 4'hF, r);
    chk("unmapped_bresp", {30'b0, r}, 32'd2);
    axi_read(8'h80, d, r);
    chk("unmapped_rresp", {30'b0, r}, 32'd2);
    chk("unmapped_rdata", d, 32'd0);
    axi_read(8'h30, d, r);
    chk("led8_rresp", {30'b0, r}, 32'd2);
    axi_read(8'h00, d, r);
    chk("ctrl_kept", d, 32'h1);
    chk("ctrl_rresp", {30'b0, r}, 32'd0);
    axi_read(8'h08, d, r);
    chk("blink_kept", d, 32'h2);
    axi_read(8'h10, d, r);
    chk("led0_kept", d, 32'h0000_5501);
    axi_write(8'h0C, 32'hFFFF_FFFF, 4'hF, r);
    chk("status_wr_bresp", {30'b0, r}, 32'd0);

    // Write back-pressure and single outstanding write
    awaddr = 8'h08; wdata = 32'h77; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (awready) got = 1'b1;
      tick1();
    end
    chk("bp_aw1", {31'b0, got}, 32'd1);
    wdata = 32'h55;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(bvalid === 1'b1 && bresp === 2'b00 && awready === 1'b0)) ok = 1'b0;
      tick1();
    end
    chk("bp_b_stable", {31'b0, ok}, 32'd1);
    bready = 1'b1;
    tick1();
    bready = 1'b0;
    chk("bp_b_done", {31'b0, bvalid}, 32'd0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (awready) got = 1'b1;
      tick1();
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bp_aw2", {31'b0, got}, 32'd1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bvalid) begin got = 1'b1; bready = 1'b1; end
      tick1();
    end
    bready = 1'b0;
    chk("bp_b2", {31'b0, got}, 32'd1);

    // Read back-pressure
    araddr = 8'h08; arvalid = 1'b1; rready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (arready) got = 1'b1;
      tick1();
    end
    arvalid = 1'b0;
    chk("bp_ar", {31'b0, got}, 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(rvalid === 1'b1 && rdata === 32'h55 && rresp === 2'b00)) ok = 1'b0;
      tick1();
    end
    chk("bp_r_stable", {31'b0, ok}, 32'd1);
    rready = 1'b1;
    tick1();
    rready = 1'b0;
    chk("bp_r_done", {31'b0, rvalid}, 32'd0);

    // Prescale width masking
    axi_write(8'h04, 32'hFFFF_FFFF, 4'hF, r);
    axi_read(8'h04, d, r);
    chk("presc_mask", d, 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
